// File: rtl/switch_port_host.sv
// Host endpoint for one port of the 4-port switch: paced TX FIFO injection and
// checked RX with optional traffic counters (enabled by SWITCH_PORT_HOST_STATS_EN).
module switch_port_host #(
  parameter int unsigned         DATA_W     = 8,
  parameter int unsigned         ADDR_W     = 4,
  parameter logic [ADDR_W-1:0]   PORT_ID    = 4'b0001,
  parameter int unsigned         FIFO_DEPTH = 4,
  parameter int unsigned         GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [ADDR_W-1:0] tx_target,
  input  logic [DATA_W-1:0] tx_data,
  output logic              sw_valid,
  output logic [ADDR_W-1:0] sw_source,
  output logic [ADDR_W-1:0] sw_target,
  output logic [DATA_W-1:0] sw_data,
  input  logic              sw_rx_valid,
  input  logic [ADDR_W-1:0] sw_rx_source,
  input  logic [ADDR_W-1:0] sw_rx_target,
  input  logic [DATA_W-1:0] sw_rx_data,
  output logic              rx_valid,
  output logic [ADDR_W-1:0] rx_source,
  output logic [DATA_W-1:0] rx_data,
  output logic [15:0]       drop_count,
  output logic [15:0]       rx_count,
  output logic [15:0]       err_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [3:0]  GAP_INIT = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  logic [ADDR_W+DATA_W-1:0] mem [FIFO_DEPTH];
  logic [ADDR_W+DATA_W-1:0] head;
  logic [PTR_W-1:0]         wr_ptr, rd_ptr;
  logic [CNT_W-1:0]         count, count_next;
  logic                     fifo_empty;
  logic                     tx_legal, push, pop;
  logic                     rx_hit;
  state_t                   state;
  logic [3:0]               gap_cnt;

  assign tx_legal   = (tx_target != '0) && ((tx_target & (tx_target - 1'b1)) == '0)
                      && (tx_target != PORT_ID);
  assign push       = tx_valid && tx_ready && tx_legal;
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];
  assign sw_source  = PORT_ID;
  assign rx_hit     = (sw_rx_target == PORT_ID);

  // The end of a gap pops directly so GAP_CYCLES idle cycles separate two injections.
  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = !fifo_empty;
      SEND:    pop = (GAP_CYCLES == 0) && !fifo_empty;
      GAP:     pop = (gap_cnt == '0) && !fifo_empty;
      default: pop = 1'b0;
    endcase
  end

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (!push && pop)
      count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {tx_target, tx_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_ready <= 1'b0;
    end else begin
      count    <= count_next;
      tx_ready <= (count_next != CNT_W'(FIFO_DEPTH));
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gap_cnt   <= '0;
      sw_valid  <= 1'b0;
      sw_target <= '0;
      sw_data   <= '0;
    end else begin
      sw_valid <= pop;
      if (pop)
        {sw_target, sw_data} <= head;
      case (state)
        IDLE: begin
          if (pop)
            state <= SEND;
        end
        SEND: begin
          if (GAP_CYCLES != 0) begin
            state   <= GAP;
            gap_cnt <= GAP_INIT;
          end else if (!pop) begin
            state <= IDLE;
          end
        end
        GAP: begin
          if (gap_cnt == '0)
            state <= pop ? SEND : IDLE;
          else
            gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_valid  <= 1'b0;
      rx_source <= '0;
      rx_data   <= '0;
    end else begin
      rx_valid <= sw_rx_valid && rx_hit;
      if (sw_rx_valid && rx_hit) begin
        rx_source <= sw_rx_source;
        rx_data   <= sw_rx_data;
      end
    end
  end

`ifdef SWITCH_PORT_HOST_STATS_EN
  logic [15:0] drop_q, rxc_q, errc_q;
  logic        drop_evt, rx_good_evt, rx_err_evt;

  assign drop_evt    = tx_valid && tx_ready && !tx_legal;
  assign rx_good_evt = sw_rx_valid && rx_hit;
  assign rx_err_evt  = sw_rx_valid && !rx_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_q <= '0;
      rxc_q  <= '0;
      errc_q <= '0;
    end else begin
      if (drop_evt && (drop_q != '1))
        drop_q <= drop_q + 1'b1;
      if (rx_good_evt && (rxc_q != '1))
        rxc_q <= rxc_q + 1'b1;
      if (rx_err_evt && (errc_q != '1))
        errc_q <= errc_q + 1'b1;
    end
  end

  assign drop_count = drop_q;
  assign rx_count   = rxc_q;
  assign err_count  = errc_q;
`else
  assign drop_count = '0;
  assign rx_count   = '0;
  assign err_count  = '0;
`endif

endmodule
